lcm_calculator: RTL and testbench
=================================

LCM_CALCULATOR -- requirements
Module: lcm_calculator

Interface
REQ-001 SHALL have parameter N, default 8, meaning the operand and GCD width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port P, input, N bits: first operand, the same value presented to the GCD stage.
REQ-005 SHALL have port Q, input, N bits: second operand, the same value presented to the GCD stage.
REQ-006 SHALL have port R, input, N bits: the GCD result from the upstream GCD stage.
REQ-007 SHALL have port gcd_valid, input, 1 bit: R is valid; level-sensitive, sampled only in IDLE.
REQ-008 SHALL have port ack, input, 1 bit: consumer has taken L.
REQ-009 SHALL have port L, output, 2N bits: the least common multiple.
REQ-010 SHALL have port lcm_valid, output, 1 bit: L is valid.
REQ-011 SHALL have port busy, output, 1 bit: high in DIV and MUL.
REQ-012 SHALL have port State_Y, output, 2 bits: current state encoding.

Function
REQ-013 SHALL implement FSM states IDLE=0, DIV=1, MUL=2, DONE=3.
REQ-014 In IDLE with gcd_valid=1 at an edge, SHALL latch P, Q and R into internal registers and enter DIV; if the latched R==0, SHALL instead set L=0 and enter DONE directly.
REQ-015 DIV SHALL compute quotient P/R by restoring shift-subtract, one quotient bit per cycle, for exactly N cycles, then enter MUL.
REQ-016 MUL SHALL compute quotient*Q by shift-add, one multiplier bit per cycle, for exactly N cycles into a 2N-bit accumulator, then load L and enter DONE.
REQ-017 Latency SHALL be: lcm_valid high starting at edge k+2N+1, where k is the capture edge (17 cycles for N=8).
REQ-018 lcm_valid SHALL equal 1 exactly in DONE; L SHALL hold stable throughout DONE.
REQ-019 In DONE, ack=1 at an edge SHALL return the FSM to IDLE; lcm_valid SHALL drop in the same cycle; L SHALL retain its value until the next result is loaded.
REQ-020 gcd_valid SHALL be ignored in DIV, MUL and DONE; operand changes after capture SHALL have no effect.
REQ-021 P=0 or Q=0 with R nonzero SHALL yield L=0 through the normal path.
REQ-022 L SHALL never overflow, since the LCM is at most P*Q, which is less than 2^(2N).
REQ-023 busy SHALL be 1 iff the state is DIV or MUL.

Reset
REQ-024 rst=0 SHALL immediately force State_Y=IDLE, L=0, lcm_valid=0, busy=0, and clear all internal registers, including mid-computation.
REQ-025 After rst rises, the first capture SHALL occur no earlier than the next rising edge with gcd_valid=1.

Configuration
REQ-026 Macro LCM_ERR_FLAG_EN SHALL, when defined, add output err, 1 bit: err=1 in DONE if the latched R==0 or the DIV remainder is nonzero (R does not divide P); err=0 otherwise; err is cleared by reset and on leaving DONE.
REQ-027 Without LCM_ERR_FLAG_EN, SHALL have no err port and no remainder check; the R==0 bypass (REQ-014) SHALL still apply.

Verification
REQ-028 SHALL verify: P=24, Q=13, R=1, gcd_valid pulse -> lcm_valid at capture+17, L=312, busy high 16 cycles.
REQ-029 SHALL verify: P=12, Q=18, R=6 -> L=36; then hold ack=0 for 5 cycles -> L and lcm_valid stable; ack=1 -> IDLE next edge.
REQ-030 SHALL verify: P=255, Q=254, R=1 -> L=64770 (maximum-range multiply).
REQ-031 SHALL verify: P=0, Q=0, R=0 -> DONE at capture+1 with L=0; with LCM_ERR_FLAG_EN, err=1.
REQ-032 SHALL verify: P=12, Q=18, R=5 with LCM_ERR_FLAG_EN -> err=1 in DONE.
REQ-033 SHALL verify: rst=0 asserted mid-DIV -> L=0, State_Y=0, busy=0 immediately; gcd_valid pulsed during MUL -> ignored, result unchanged.

Source files
------------

// File: rtl/lcm_calculator.sv
// lcm_calculator: LCM = (P / GCD) * Q, using a sequential restoring divider
// followed by a sequential shift-add multiplier.
// Takes the GCD from an upstream stage on R. Holds the result until ack.
// Optional feature macro: LCM_ERR_FLAG_EN adds the err output, which flags
// R==0 or a nonzero division remainder.
//
// state | meaning
// IDLE  | waiting for gcd_valid; operands are captured on that edge
// DIV   | P/R, one quotient bit per cycle, N cycles
// MUL   | quotient*Q, one multiplier bit per cycle, N cycles
// DONE  | L valid, held until ack
module lcm_calculator #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   P,
   input  logic [N-1:0]   Q,
   input  logic [N-1:0]   R,
   input  logic           gcd_valid,
   input  logic           ack,
   output logic [2*N-1:0] L,
   output logic           lcm_valid,
   output logic           busy,
`ifdef LCM_ERR_FLAG_EN
   output logic           err,
`endif
   output logic [1:0]     State_Y
);

   localparam int            CW       = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   // quo_r is the dividend/quotient during DIV and the multiplier during MUL.
   logic [N-1:0]   r_r;
   logic [N-1:0]   quo_r;
   logic [N:0]     rem_r;
   logic [2*N-1:0] mcand_r;
   logic [2*N-1:0] acc_r;
   logic [CW-1:0]  cnt_r;

   logic [N:0]     rem_sh;
   logic           div_fit;
   logic [N:0]     rem_nxt;
   logic [2*N-1:0] acc_nxt;
   logic           cnt_last;

   assign rem_sh   = {rem_r[N-1:0], quo_r[N-1]};
   assign div_fit  = (rem_sh >= {1'b0, r_r});
   assign rem_nxt  = div_fit ? (rem_sh - {1'b0, r_r}) : rem_sh;
   assign acc_nxt  = quo_r[0] ? (acc_r + mcand_r) : acc_r;
   assign cnt_last = (cnt_r == '0);

   assign State_Y   = state;
   assign lcm_valid = (state == DONE);
   assign busy      = (state == DIV) || (state == MUL);

`ifdef LCM_ERR_FLAG_EN
   // r_r and rem_r are left untouched in DONE, so the check can be combinational.
   assign err = (state == DONE) && ((r_r == '0) || (rem_r != '0));
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (gcd_valid) state_nxt = (R == '0) ? DONE : DIV;
         DIV:  if (cnt_last)  state_nxt = MUL;
         MUL:  if (cnt_last)  state_nxt = DONE;
         DONE: if (ack)       state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, divide step, multiply step, result load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_r     <= '0;
         quo_r   <= '0;
         rem_r   <= '0;
         mcand_r <= '0;
         acc_r   <= '0;
         cnt_r   <= '0;
         L       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gcd_valid) begin
                  r_r     <= R;
                  quo_r   <= P;
                  rem_r   <= '0;
                  mcand_r <= {{N{1'b0}}, Q};
                  acc_r   <= '0;
                  cnt_r   <= CNT_LAST;
                  if (R == '0) L <= '0;
               end
            end
            DIV: begin
               rem_r <= rem_nxt;
               quo_r <= (quo_r << 1) | N'(div_fit);
               cnt_r <= cnt_last ? CNT_LAST : cnt_r - 1'b1;
            end
            MUL: begin
               acc_r   <= acc_nxt;
               mcand_r <= mcand_r << 1;
               quo_r   <= quo_r >> 1;
               cnt_r   <= cnt_last ? '0 : cnt_r - 1'b1;
               if (cnt_last) L <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_calculator.sv
// Directed bench for lcm_calculator (N=8), with hand-computed results.
// Edge numbering: the capture edge is edge 1. A normal result is first
// visible after edge 17. The R==0 bypass result is visible after edge 1.
module tb_lcm_calculator;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   P = '0, Q = '0, R = '0;
   logic           gcd_valid = 1'b0;
   logic           ack = 1'b0;
   logic [2*N-1:0] L;
   logic           lcm_valid;
   logic           busy;
   logic [1:0]     State_Y;
`ifdef LCM_ERR_FLAG_EN
   logic           err;
`endif

   int total = 0;
   int bad   = 0;

   lcm_calculator #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .P         (P),
      .Q         (Q),
      .R         (R),
      .gcd_valid (gcd_valid),
      .ack       (ack),
      .L         (L),
      .lcm_valid (lcm_valid),
      .busy      (busy),
`ifdef LCM_ERR_FLAG_EN
      .err       (err),
`endif
      .State_Y   (State_Y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Present operands with gcd_valid high for exactly one capture edge.
   task automatic start(input logic [N-1:0] p, input logic [N-1:0] q, input logic [N-1:0] r);
      @(negedge clk);
      P = p; Q = q; R = r; gcd_valid = 1'b1;
      @(posedge clk);
      #1 gcd_valid = 1'b0;
   endtask

   // Returns the edge number at which lcm_valid first appears and the
   // number of busy cycles seen before it. The wait is bounded.
   task automatic wait_done(output int edges, output int busy_cnt);
      edges = 1;
      busy_cnt = 0;
      @(negedge clk);
      while (!lcm_valid && edges < 60) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
   endtask

   int edges, bcnt;

   initial begin
      // Reset state
      #12;
      chk("rst_state", State_Y, 0);
      chk("rst_L", L, 0);
      chk("rst_valid", lcm_valid, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_hold", State_Y, 0);

      // 24*13 / 1: latency and busy length
      start(8'd24, 8'd13, 8'd1);
      wait_done(edges, bcnt);
      chk("t1_latency", edges, 17);
      chk("t1_busy_cycles", bcnt, 16);
      chk("t1_L", L, 312);
      chk("t1_state", State_Y, 3);
`ifdef LCM_ERR_FLAG_EN
      chk("t1_err", err, 0);
`endif
      do_ack();

      // 12,18 / 6: hold without ack, then ack
      start(8'd12, 8'd18, 8'd6);
      wait_done(edges, bcnt);
      chk("t2_L", L, 36);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_hold_L", L, 36);
         chk("t2_hold_valid", lcm_valid, 1);
      end
      do_ack();
      chk("t2_ack_state", State_Y, 0);
      chk("t2_ack_valid", lcm_valid, 0);
      chk("t2_L_retained", L, 36);

      // Maximum-range multiply
      start(8'd255, 8'd254, 8'd1);
      wait_done(edges, bcnt);
      chk("t3_latency", edges, 17);
      chk("t3_L", L, 64770);
      do_ack();

      // R==0 bypass
      start(8'd0, 8'd0, 8'd0);
      wait_done(edges, bcnt);
      chk("t4_latency", edges, 1);
      chk("t4_L", L, 0);
      chk("t4_busy_cycles", bcnt, 0);
`ifdef LCM_ERR_FLAG_EN
      chk("t4_err", err, 1);
`endif
      do_ack();

      // R does not divide P: quotient 2, so L = 36
      start(8'd12, 8'd18, 8'd5);
      wait_done(edges, bcnt);
      chk("t5_L", L, 36);
`ifdef LCM_ERR_FLAG_EN
      chk("t5_err", err, 1);
`endif
      do_ack();
`ifdef LCM_ERR_FLAG_EN
      chk("t5_err_cleared", err, 0);
`endif

      // Zero operands with a nonzero R go through the normal path
      start(8'd0, 8'd7, 8'd3);
      wait_done(edges, bcnt);
      chk("t6_latency", edges, 17);
      chk("t6_L", L, 0);
      do_ack();
      start(8'd9, 8'd0, 8'd3);
      wait_done(edges, bcnt);
      chk("t7_L", L, 0);
      do_ack();

      // Load a nonzero L, then reset in the middle of DIV
      start(8'd20, 8'd3, 8'd1);
      wait_done(edges, bcnt);
      chk("t8_L", L, 60);
      do_ack();
      start(8'd200, 8'd3, 8'd2);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("t8_rst_L", L, 0);
      chk("t8_rst_state", State_Y, 0);
      chk("t8_rst_busy", busy, 0);
      chk("t8_rst_valid", lcm_valid, 0);
      @(negedge clk);
      rst = 1'b1;

      // gcd_valid and operand changes during MUL are ignored
      start(8'd12, 8'd18, 8'd6);
      repeat (11) @(posedge clk);
      @(negedge clk);
      chk("t9_in_mul", State_Y, 2);
      P = 8'd100; Q = 8'd100; R = 8'd1; gcd_valid = 1'b1;
      repeat (2) @(negedge clk);
      gcd_valid = 1'b0;
      edges = 0;
      while (!lcm_valid && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      chk("t9_valid", lcm_valid, 1);
      chk("t9_L", L, 36);
      do_ack();
      @(negedge clk);
      chk("t9_idle", State_Y, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
